// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive front end: line-state codes,
// receiver FSM states and small framing constants.
package usb_pkg;

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR
  } rx_state_t;

  localparam int SYNC_ZEROS_MIN = 3;
  localparam int IDLE_J_BITS    = 8;

  // True for the two differential data levels, false for SE0/SE1.
  function automatic logic is_jk(input logic [1:0] ls);
    return (ls == LS_J) || (ls == LS_K);
  endfunction

endpackage

// File: rtl/usb_rx_decode_if.sv
// Decoded receive stream and line status handed from the decoder to the packet layer.
interface usb_rx_decode_if;

  logic [1:0] line_state;
  logic       bit_valid;
  logic       bit_out;
  logic       rx_active;
  logic       eop;
  logic       stuff_err;
  logic       se0;
  logic       usb_reset;

  modport master (
    output line_state, bit_valid, bit_out, rx_active, eop, stuff_err, se0, usb_reset
  );

  modport slave (
    input line_state, bit_valid, bit_out, rx_active, eop, stuff_err, se0, usb_reset
  );

endinterface

// File: rtl/usb_rx_dpll.sv
// Input synchroniser with low-speed polarity swap and an edge-locked 2-bit
// phase counter that marks the mid-bit sample point of each 4x-oversampled cell.
module usb_rx_dpll
  import usb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk4x,
  input  logic       reset,
  input  logic       low_speed,
  input  logic       dp,
  input  logic       dn,
  output logic [1:0] line_state,
  output logic       sample
);

  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] prev_ls;
  logic [1:0] phase;
  logic [1:0] phase_now;
  logic       jk_edge;

  // Synchroniser chain; the swap happens on entry so every stage already holds J/K-relative codes.
  always_ff @(posedge clk4x) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= LS_J;
    end else begin
      sync_q[0] <= low_speed ? {dn, dp} : {dp, dn};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign line_state = sync_q[SYNC_STAGES-1];

  // Only a direct J<->K transition realigns the bit clock; single-ended states never do.
  assign jk_edge   = is_jk(line_state) && is_jk(prev_ls) && (line_state != prev_ls);
  assign phase_now = jk_edge ? 2'd0 : phase;
  assign sample    = (phase_now == 2'd2);

  // Free-running phase counter, treating the edge cycle itself as phase 0.
  always_ff @(posedge clk4x) begin
    if (reset) begin
      prev_ls <= LS_J;
      phase   <= 2'd0;
    end else begin
      prev_ls <= line_state;
      phase   <= phase_now + 2'd1;
    end
  end

endmodule

// File: rtl/usb_rx_decode.sv
// USB receive decoder: NRZI decode, bit unstuffing, SYNC/EOP framing FSM and
// bus-reset timer on top of the oversampling DPLL.
module usb_rx_decode
  import usb_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STUFF_LIMIT  = 6,
  parameter int RESET_CYCLES = 10000
) (
  input  logic      clk4x,
  input  logic      reset,
  input  logic      low_speed,
  input  logic      dp,
  input  logic      dn,
  usb_rx_decode_if.master rx
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  logic [1:0]    ls;
  logic          sample;
  logic          dec;
  logic [1:0]    prev_level;
  rx_state_t     state;
  logic [OW-1:0] ones;
  logic [1:0]    zeros;
  logic [1:0]    se0_seen;
  logic [3:0]    j_seen;
  logic [RW-1:0] se0_cycles;
  logic          usb_reset_q;
  logic          bit_valid_q;
  logic          bit_out_q;
  logic          rx_active_q;
  logic          eop_q;
  logic          stuff_err_q;

  usb_rx_dpll #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dpll (
    .clk4x      (clk4x),
    .reset      (reset),
    .low_speed  (low_speed),
    .dp         (dp),
    .dn         (dn),
    .line_state (ls),
    .sample     (sample)
  );

  // NRZI: an unchanged level is a 1, a change is a 0.
  assign dec = (ls == prev_level);

  // Framing FSM; acts only on sample points and registers every output strobe.
  always_ff @(posedge clk4x) begin
    if (reset) begin
      state       <= IDLE;
      prev_level  <= LS_J;
      ones        <= '0;
      zeros       <= '0;
      se0_seen    <= '0;
      j_seen      <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      rx_active_q <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      eop_q       <= 1'b0;
      stuff_err_q <= 1'b0;
      if (usb_reset_q) begin
        state       <= IDLE;
        prev_level  <= LS_J;
        rx_active_q <= 1'b0;
        ones        <= '0;
      end else if (sample) begin
        if (is_jk(ls)) prev_level <= ls;
        case (state)
          IDLE: begin
            prev_level <= (ls == LS_K) ? LS_K : LS_J;
            if (ls == LS_K) begin
              state <= SYNC;
              zeros <= 2'd1;
            end
          end
          SYNC: begin
            if (ls == LS_SE0) begin
              state <= IDLE;
            end else if (ls == LS_SE1) begin
              state  <= ERR;
              j_seen <= '0;
            end else if (dec) begin
              if (zeros >= 2'(SYNC_ZEROS_MIN)) begin
                state       <= DATA;
                rx_active_q <= 1'b1;
                ones        <= '0;
              end else begin
                state <= IDLE;
              end
            end else if (zeros < 2'(SYNC_ZEROS_MIN)) begin
              zeros <= zeros + 2'd1;
            end
          end
          DATA: begin
            if (ls == LS_SE0) begin
              state    <= EOP;
              se0_seen <= 2'd1;
            end else if (ls == LS_SE1) begin
              state       <= ERR;
              rx_active_q <= 1'b0;
              j_seen      <= '0;
            end else if (ones == OW'(STUFF_LIMIT)) begin
              if (dec) begin
                stuff_err_q <= 1'b1;
                rx_active_q <= 1'b0;
                state       <= ERR;
                j_seen      <= '0;
              end else begin
                ones <= '0;
              end
            end else begin
              bit_valid_q <= 1'b1;
              bit_out_q   <= dec;
              ones        <= dec ? ones + 1'b1 : '0;
            end
          end
          EOP: begin
            if (ls == LS_SE0) begin
              if (se0_seen == 2'd2) begin
                state       <= ERR;
                rx_active_q <= 1'b0;
                j_seen      <= '0;
              end else begin
                se0_seen <= se0_seen + 2'd1;
              end
            end else if (ls == LS_J) begin
              eop_q       <= 1'b1;
              rx_active_q <= 1'b0;
              state       <= IDLE;
            end else begin
              state       <= ERR;
              rx_active_q <= 1'b0;
              j_seen      <= '0;
            end
          end
          ERR: begin
            if (ls == LS_J) begin
              if (j_seen == 4'(IDLE_J_BITS - 1)) begin
                state  <= IDLE;
                j_seen <= '0;
              end else begin
                j_seen <= j_seen + 4'd1;
              end
            end else begin
              j_seen <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bus-reset timer counts raw clk4x cycles of SE0, independent of the bit clock.
  always_ff @(posedge clk4x) begin
    if (reset) begin
      se0_cycles  <= '0;
      usb_reset_q <= 1'b0;
    end else if (ls != LS_SE0) begin
      se0_cycles  <= '0;
      usb_reset_q <= 1'b0;
    end else begin
      if (se0_cycles != RW'(RESET_CYCLES)) se0_cycles <= se0_cycles + 1'b1;
      if (se0_cycles >= RW'(RESET_CYCLES - 1)) usb_reset_q <= 1'b1;
    end
  end

  assign rx.line_state = ls;
  assign rx.se0        = (ls == LS_SE0);
  assign rx.bit_valid  = bit_valid_q;
  assign rx.bit_out    = bit_out_q;
  assign rx.rx_active  = rx_active_q;
  assign rx.eop        = eop_q;
  assign rx.stuff_err  = stuff_err_q;
  assign rx.usb_reset  = usb_reset_q;

endmodule

// File: tb/tb_usb_rx_decode.sv
// Bench for usb_rx_decode: encodes packets from plain bit lists (SYNC, NRZI,
// bit stuffing, EOP) onto dp/dn and compares the decoded stream to the source bits.
module tb_usb_rx_decode;

  localparam int SYNC_STAGES  = 2;
  localparam int STUFF_LIMIT  = 6;
  localparam int RESET_CYCLES = 300;

  typedef bit bitq_t[$];

  logic clk4x     = 1'b0;
  logic reset     = 1'b1;
  logic low_speed = 1'b0;
  logic dp        = 1'b1;
  logic dn        = 1'b0;

  usb_rx_decode_if rx ();

  usb_rx_decode #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STUFF_LIMIT  (STUFF_LIMIT),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clk4x     (clk4x),
    .reset     (reset),
    .low_speed (low_speed),
    .dp        (dp),
    .dn        (dn),
    .rx        (rx)
  );

  // 4x bit clock
  always #5 clk4x = ~clk4x;

  int    errors = 0;
  int    checks = 0;
  bitq_t got_bits;
  int    eop_cnt, err_cnt, both_cnt, valid_inactive, active_at_strobe;
  int    jitter_mode = 0;
  int    cell_idx    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Collect decoded bits and strobes away from the active edge
  always @(negedge clk4x) begin
    if (!reset) begin
      if (rx.bit_valid) begin
        got_bits.push_back(rx.bit_out);
        if (!rx.rx_active) valid_inactive++;
      end
      if (rx.eop) begin
        eop_cnt++;
        if (rx.rx_active) active_at_strobe++;
      end
      if (rx.stuff_err) begin
        err_cnt++;
        if (rx.rx_active) active_at_strobe++;
      end
      if (rx.eop && rx.stuff_err) both_cnt++;
    end
  end

  task automatic clearMonitor();
    got_bits.delete();
    eop_cnt = 0; err_cnt = 0; both_cnt = 0; valid_inactive = 0; active_at_strobe = 0;
  endtask

  function automatic bitq_t addByte(input bitq_t q, input logic [7:0] b);
    bitq_t r = q;
    for (int i = 0; i < 8; i++) r.push_back(b[i]);
    return r;
  endfunction

  // One bit cell at a J/K-relative level; nominal 4 clocks or alternating 3/5
  task automatic driveCell(input logic [1:0] lvl);
    int len;
    len = (jitter_mode != 0) ? (((cell_idx % 2) == 0) ? 3 : 5) : 4;
    cell_idx++;
    {dp, dn} = low_speed ? {lvl[0], lvl[1]} : lvl;
    repeat (len) @(posedge clk4x);
    #1;
  endtask

  task automatic idleCells(input int n);
    repeat (n) driveCell(2'b10);
  endtask

  task automatic setSpeed(input logic s);
    low_speed = s;
    {dp, dn} = s ? 2'b01 : 2'b10;
    idleCells(6);
  endtask

  // SYNC, NRZI data with optional stuffing, optional SE1 injection/abort, then SE0 cells
  task automatic applyStimulus(input bitq_t data, input bit do_stuff, input int se0_cells,
                               input int se1_at, input int abort_at);
    logic [1:0] lvl;
    int ones;
    cell_idx = 0;
    lvl = 2'b10;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) lvl = ~lvl;
      driveCell(lvl);
    end
    ones = 0;
    for (int i = 0; i < data.size(); i++) begin
      if (i == abort_at) return;
      if (i == se1_at) begin
        driveCell(2'b11);
        ones = 0;
      end else begin
        if (!data[i]) lvl = ~lvl;
        driveCell(lvl);
        ones = data[i] ? ones + 1 : 0;
        if (do_stuff && ones == STUFF_LIMIT) begin
          lvl = ~lvl;
          driveCell(lvl);
          ones = 0;
        end
      end
    end
    repeat (se0_cells) driveCell(2'b00);
  endtask

  task automatic checkPacket(input string tag, input bitq_t exp_bits, input int exp_eop, input int exp_err);
    checkOutput({tag, ".bits"}, got_bits.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
      checkOutput($sformatf("%s.bit%0d", tag, i), got_bits[i], exp_bits[i]);
    checkOutput({tag, ".eop"}, eop_cnt, exp_eop);
    checkOutput({tag, ".stuff_err"}, err_cnt, exp_err);
    checkOutput({tag, ".valid_wo_active"}, valid_inactive, 0);
    checkOutput({tag, ".active_at_strobe"}, active_at_strobe, 0);
    checkOutput({tag, ".eop_and_err"}, both_cnt, 0);
    checkOutput({tag, ".rx_active_end"}, rx.rx_active, 0);
  endtask

  task automatic runPacket(input string tag, input bitq_t data, input int se0_cells, input int exp_eop);
    clearMonitor();
    applyStimulus(data, 1'b1, se0_cells, -1, -1);
    idleCells(12);
    checkPacket(tag, data, exp_eop, 0);
  endtask

  bitq_t pkt_a5, pkt_ff, pkt_bad, pkt_exp, pkt_rand, pkt_two;

  initial begin
    pkt_a5 = addByte(pkt_a5, 8'hA5);
    pkt_ff = addByte(addByte(pkt_ff, 8'hFF), 8'hFF);
    pkt_bad = '{1, 0, 1, 1, 1, 1, 1, 1, 1};
    pkt_exp = '{1, 0, 1, 1, 1, 1, 1, 1};
    pkt_two = addByte(addByte(pkt_two, 8'h5A), 8'hC3);

    repeat (3) @(posedge clk4x);
    @(negedge clk4x);
    checkOutput("rst.line_state", rx.line_state, 2'b10);
    checkOutput("rst.outputs", {rx.bit_valid, rx.bit_out, rx.rx_active, rx.eop,
                                rx.stuff_err, rx.se0, rx.usb_reset}, 0);
    @(posedge clk4x);
    #1 reset = 1'b0;
    idleCells(6);

    runPacket("fs_a5", pkt_a5, 2, 1);
    runPacket("stuffed_ffff", pkt_ff, 2, 1);

    // Stuff violation, then a packet during the ERR lockout is ignored
    clearMonitor();
    applyStimulus(pkt_bad, 1'b0, 0, -1, -1);
    idleCells(3);
    applyStimulus(pkt_a5, 1'b1, 2, -1, -1);
    idleCells(12);
    checkPacket("stuff_err", pkt_exp, 0, 1);
    runPacket("after_err", pkt_two, 2, 1);

    jitter_mode = 1;
    runPacket("jitter_a5", pkt_a5, 2, 1);
    jitter_mode = 0;

    setSpeed(1'b1);
    runPacket("ls_a5", pkt_a5, 2, 1);
    setSpeed(1'b0);

    runPacket("eop_1se0", pkt_a5, 1, 1);
    runPacket("eop_3se0", pkt_a5, 3, 0);

    clearMonitor();
    applyStimulus(pkt_a5, 1'b1, 2, 4, -1);
    idleCells(12);
    pkt_exp = '{1, 0, 1, 0};
    checkPacket("se1_data", pkt_exp, 0, 0);

    for (int n = 0; n < 6; n++) begin
      pkt_rand.delete();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++)
        pkt_rand = addByte(pkt_rand, 8'($urandom_range(0, 255)));
      jitter_mode = int'($urandom_range(0, 1));
      setSpeed(1'($urandom_range(0, 1)));
      runPacket($sformatf("rand%0d", n), pkt_rand, 2, 1);
    end
    jitter_mode = 0;
    setSpeed(1'b0);

    // Bus reset timing
    {dp, dn} = 2'b00;
    repeat (RESET_CYCLES + SYNC_STAGES - 1) @(posedge clk4x);
    @(negedge clk4x);
    checkOutput("usb_reset.early", rx.usb_reset, 0);
    checkOutput("usb_reset.se0", rx.se0, 1);
    @(posedge clk4x);
    @(negedge clk4x);
    checkOutput("usb_reset.assert", rx.usb_reset, 1);
    @(posedge clk4x);
    #1 {dp, dn} = 2'b10;
    repeat (SYNC_STAGES) @(posedge clk4x);
    @(negedge clk4x);
    checkOutput("usb_reset.hold", rx.usb_reset, 1);
    checkOutput("usb_reset.se0_clear", rx.se0, 0);
    @(posedge clk4x);
    @(negedge clk4x);
    checkOutput("usb_reset.release", rx.usb_reset, 0);
    @(posedge clk4x);
    #1;
    idleCells(6);
    runPacket("after_busreset", pkt_a5, 2, 1);

    // Reset in the middle of the second byte
    clearMonitor();
    applyStimulus(pkt_two, 1'b1, 0, -1, 12);
    @(negedge clk4x);
    checkOutput("midrst.active_before", rx.rx_active, 1);
    @(posedge clk4x);
    #1;
    reset = 1'b1;
    {dp, dn} = 2'b10;
    @(posedge clk4x);
    @(negedge clk4x);
    checkOutput("midrst.line_state", rx.line_state, 2'b10);
    checkOutput("midrst.outputs", {rx.bit_valid, rx.bit_out, rx.rx_active, rx.eop,
                                   rx.stuff_err, rx.se0, rx.usb_reset}, 0);
    @(posedge clk4x);
    #1 reset = 1'b0;
    clearMonitor();
    driveCell(2'b00);
    driveCell(2'b00);
    idleCells(12);
    checkOutput("midrst.eop", eop_cnt, 0);
    checkOutput("midrst.stuff_err", err_cnt, 0);
    runPacket("after_midrst", pkt_a5, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
